// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one request/ready/valid memory port between fetch and data, data-first with fetch starvation guard
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_imem_req,
   input  logic [31:0] i_imem_addr,
   output logic        o_imem_ready,
   output logic        o_imem_valid,
   output logic [31:0] o_imem_rdata,
   input  logic        i_dmem_req,
   input  logic [31:0] i_dmem_addr,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_dmem_wdata,
   input  logic [3:0]  i_dmem_mask,
   output logic        o_dmem_ready,
   output logic        o_dmem_valid,
   output logic [31:0] o_dmem_rdata,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic        i_mem_ready,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t      state;
   logic        owner;
   logic [3:0]  starve_cnt;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_wen;
   logic [3:0]  lat_mask;
   logic        idle;
   logic        starved;
   logic        grant_d;
   logic        grant_i;
   logic        resp;
   logic [31:0] sel_addr;
   always_comb begin
      idle     = state == IDLE && !i_rst;
      starved  = i_imem_req && starve_cnt == 4'(STARVE_LIMIT);
      grant_d  = idle && i_dmem_req && !starved;
      grant_i  = idle && i_imem_req && !grant_d;
      resp     = state == WAIT && i_mem_valid && !i_rst;
      sel_addr = grant_d ? i_dmem_addr : i_imem_addr;
   end
   assign o_imem_ready = grant_i;
   assign o_dmem_ready = grant_d;
   assign o_imem_valid = resp && !owner;
   assign o_dmem_valid = resp && owner;
   assign o_imem_rdata = o_imem_valid ? i_mem_rdata : '0;
   assign o_dmem_rdata = o_dmem_valid ? i_mem_rdata : '0;
   assign o_mem_req    = state == ISSUE;
   assign o_mem_addr   = lat_addr;
   assign o_mem_wen    = lat_wen;
   assign o_mem_wdata  = lat_wdata;
   assign o_mem_mask   = lat_mask;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         starve_cnt <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_wen    <= 1'b0;
         lat_mask   <= '0;
      end else if (state == IDLE) begin
         if (grant_d || grant_i) begin
            owner     <= grant_d;
            lat_addr  <= sel_addr & ~32'd3;
            lat_wen   <= grant_d && i_dmem_wen;
            lat_wdata <= grant_d ? i_dmem_wdata : '0;
            lat_mask  <= grant_d ? i_dmem_mask : 4'hF;
            state     <= ISSUE;
         end
         starve_cnt <= (grant_i || !i_imem_req) ? '0 :
                       !grant_d ? starve_cnt :
                       starve_cnt == 4'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 4'd1;
      end else if (state == ISSUE) begin
         state <= i_mem_ready ? WAIT : ISSUE;
      end else begin
         state <= i_mem_valid ? IDLE : WAIT;
      end
   end
endmodule
